// File: rtl/pipe_ctrl_unit.sv
// Pipeline control for the decode stage: buffer enables/flushes, load-use stalls,
// branch squash and the interrupt entry sequence (drain, push PC hi/lo, load vector).
module pipe_ctrl_unit #(
    parameter int REG_AW       = 3,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              intr,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              branch_taken,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_flush,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              int_push,
    output logic              int_push_hi,
    output logic              pc_load_vector,
    output logic              int_busy
);

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
        S_DRAIN   = 3'd1,
        S_PUSH_HI = 3'd2,
        S_PUSH_LO = 3'd3,
        S_VECTOR  = 3'd4
    } state_t;

    localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [2:0]  drain_cnt_reg, drain_cnt_next;
    logic        intr_q_reg;
    logic        int_pending_reg, int_pending_next;
    logic        intr_edge;
    logic        enter_drain;
    logic        lu;

    logic [REG_AW-1:0] src_addr [2];
    logic [1:0]        src_use;
    logic [1:0]        src_hit;

    assign src_addr[0] = id_rs1;
    assign src_addr[1] = id_rs2;
    assign src_use     = {id_use_rs2, id_use_rs1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_use[gi] && (src_addr[gi] == ex_rd);
        end
    endgenerate

    assign lu        = ex_mem_read && (|src_hit);
    assign intr_edge = intr && !intr_q_reg;

    // A fresh edge wins over the clear so an edge arriving on the entry cycle is not lost.
    assign int_pending_next = (int_pending_reg && !enter_drain) || intr_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_RUN;
            drain_cnt_reg   <= 3'd0;
            intr_q_reg      <= 1'b0;
            int_pending_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            drain_cnt_reg   <= drain_cnt_next;
            intr_q_reg      <= intr;
            int_pending_reg <= int_pending_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        enter_drain    = 1'b0;
        pc_en          = 1'b1;
        ifid_en        = 1'b1;
        ifid_flush     = 1'b0;
        idex_en        = 1'b1;
        idex_flush     = 1'b0;
        exmem_en       = 1'b1;
        memwb_en       = 1'b1;
        int_push       = 1'b0;
        int_push_hi    = 1'b0;
        pc_load_vector = 1'b0;
        int_busy       = 1'b0;

        case (state_reg)
            S_RUN: begin
                if (branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (lu) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end else if (int_pending_reg) begin
                    state_next     = S_DRAIN;
                    drain_cnt_next = DRAIN_LAST;
                    enter_drain    = 1'b1;
                end
            end
            S_DRAIN: begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                int_busy   = 1'b1;
                if (drain_cnt_reg == 3'd0) begin
                    state_next = S_PUSH_HI;
                end else begin
                    drain_cnt_next = drain_cnt_reg - 3'd1;
                end
            end
            S_PUSH_HI: begin
                pc_en       = 1'b0;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                int_push    = 1'b1;
                int_push_hi = 1'b1;
                int_busy    = 1'b1;
                state_next  = S_PUSH_LO;
            end
            S_PUSH_LO: begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                int_push   = 1'b1;
                int_busy   = 1'b1;
                state_next = S_VECTOR;
            end
            S_VECTOR: begin
                pc_load_vector = 1'b1;
                ifid_flush     = 1'b1;
                idex_flush     = 1'b1;
                int_busy       = 1'b1;
                state_next     = S_RUN;
            end
            default: begin
                state_next = S_RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboarded bench for pipe_ctrl_unit: stimulus queues the expected output vector
// for each cycle, a negedge monitor pops and compares.
module tb_pipe_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       intr;
    logic       ex_mem_read;
    logic [2:0] ex_rd, id_rs1, id_rs2;
    logic       id_use_rs1, id_use_rs2, branch_taken;
    logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
    logic       int_push, int_push_hi, pc_load_vector, int_busy;

    pipe_ctrl_unit #(.REG_AW(3), .DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .intr(intr),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .branch_taken(branch_taken),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .int_push(int_push), .int_push_hi(int_push_hi), .pc_load_vector(pc_load_vector),
        .int_busy(int_busy)
    );

    always #5 clk = ~clk;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
    //  int_push, int_push_hi, pc_load_vector, int_busy}
    logic [10:0] outs;
    assign outs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
                   int_push, int_push_hi, pc_load_vector, int_busy};

    localparam logic [10:0] RUN_N = 11'b1_1_0_1_0_1_1_0_0_0_0;
    localparam logic [10:0] BR    = 11'b1_1_1_1_1_1_1_0_0_0_0;
    localparam logic [10:0] LU    = 11'b0_0_0_1_1_1_1_0_0_0_0;
    localparam logic [10:0] DR    = 11'b0_1_1_1_1_1_1_0_0_0_1;
    localparam logic [10:0] PHI   = 11'b0_1_1_1_1_1_1_1_1_0_1;
    localparam logic [10:0] PLO   = 11'b0_1_1_1_1_1_1_1_0_0_1;
    localparam logic [10:0] VEC   = 11'b1_1_1_1_1_1_1_0_0_1_1;

    typedef struct {
        logic [10:0] exp;
        string       name;
    } item_t;

    item_t sb_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string n, input logic [10:0] act, input logic [10:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", n, act, exp, $time);
        end
    endtask

    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                check(it.name, outs, it.exp);
                $display("cycle %-20s outs=%b exp=%b", it.name, outs, it.exp);
            end
        end
    end

    task automatic cyc(input logic [10:0] e, input string n);
        item_t it;
        it.exp  = e;
        it.name = n;
        sb_q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ex_mem_read  = 1'b0;
        ex_rd        = 3'd0;
        id_rs1       = 3'd1;
        id_rs2       = 3'd2;
        id_use_rs1   = 1'b0;
        id_use_rs2   = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic intr_seq(input string tag);
        for (int i = 0; i < 3; i++) cyc(DR, {tag, "_drain"});
        cyc(PHI, {tag, "_push_hi"});
        cyc(PLO, {tag, "_push_lo"});
        cyc(VEC, {tag, "_vector"});
    endtask

    initial begin
        rst  = 1'b1;
        intr = 1'b0;
        clr();
        @(posedge clk);
        #1;
        cyc(RUN_N, "reset_hold");
        cyc(RUN_N, "reset_hold2");
        rst = 1'b0;
        cyc(RUN_N, "post_reset");

        // load-use hazards
        ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs2 = 3'd3; id_use_rs2 = 1'b1;
        cyc(LU, "lu_rs2");
        ex_mem_read = 1'b0;
        cyc(RUN_N, "lu_release");
        ex_mem_read = 1'b1; id_use_rs2 = 1'b0;
        cyc(RUN_N, "lu_rs2_unused");
        id_rs1 = 3'd3; id_use_rs1 = 1'b1;
        cyc(LU, "lu_rs1");
        ex_rd = 3'd4;
        cyc(RUN_N, "lu_rs1_mismatch");

        // branch overrides load-use
        clr();
        ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs2 = 3'd3; id_use_rs2 = 1'b1; branch_taken = 1'b1;
        cyc(BR, "branch_over_lu");
        clr();
        cyc(RUN_N, "after_branch");

        // held interrupt: one sequence, hazards ignored while busy
        intr = 1'b1;
        cyc(RUN_N, "t4_edge");
        cyc(RUN_N, "t4_sample");
        branch_taken = 1'b1;
        cyc(DR, "t4_drain_ign_br");
        clr();
        ex_mem_read = 1'b1; ex_rd = 3'd2; id_rs1 = 3'd2; id_use_rs1 = 1'b1;
        cyc(DR, "t4_drain_ign_lu");
        clr();
        cyc(DR, "t4_drain");
        cyc(PHI, "t4_push_hi");
        cyc(PLO, "t4_push_lo");
        cyc(VEC, "t4_vector");
        for (int i = 0; i < 12; i++) cyc(RUN_N, "t4_intr_held");
        intr = 1'b0;
        cyc(RUN_N, "t4_intr_low");

        // edge coincident with a load-use stall
        intr = 1'b1;
        ex_mem_read = 1'b1; ex_rd = 3'd5; id_rs1 = 3'd5; id_use_rs1 = 1'b1;
        cyc(LU, "t5_edge_with_lu");
        clr();
        cyc(RUN_N, "t5_sample");
        intr_seq("t5");
        cyc(RUN_N, "t5_done");
        intr = 1'b0;
        cyc(RUN_N, "t5_intr_low");

        // pending entry deferred by a taken branch
        intr = 1'b1;
        cyc(RUN_N, "t5b_edge");
        branch_taken = 1'b1;
        cyc(BR, "t5b_defer_br");
        clr();
        cyc(RUN_N, "t5b_entry");
        intr_seq("t5b");
        cyc(RUN_N, "t5b_done");
        intr = 1'b0;
        cyc(RUN_N, "t5b_intr_low");

        // second edge during PUSH_LO
        intr = 1'b1;
        cyc(RUN_N, "t6_edge");
        cyc(RUN_N, "t6_sample");
        for (int i = 0; i < 3; i++) cyc(DR, "t6_drain");
        intr = 1'b0;
        cyc(PHI, "t6_push_hi");
        intr = 1'b1;
        cyc(PLO, "t6_push_lo_edge");
        cyc(VEC, "t6_vector");
        cyc(RUN_N, "t6_gap");
        intr_seq("t6b");
        for (int i = 0; i < 3; i++) cyc(RUN_N, "t6_no_third");
        intr = 1'b0;
        cyc(RUN_N, "t6_intr_low");

        // asynchronous reset during PUSH_HI
        intr = 1'b1;
        cyc(RUN_N, "t7_edge");
        cyc(RUN_N, "t7_sample");
        for (int i = 0; i < 3; i++) cyc(DR, "t7_drain");
        check("t7_in_push_hi", outs, PHI);
        rst  = 1'b1;
        intr = 1'b0;
        #1;
        check("t7_rst_async", outs, RUN_N);
        cyc(RUN_N, "t7_rst_held");
        rst = 1'b0;
        for (int i = 0; i < 8; i++) cyc(RUN_N, "t7_no_vector");

        #20;
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
